// File: rtl/spi_peripheral_if.sv
// Fabric-side byte interface of spi_peripheral: receive strobe and transmit ready/valid handshake.
// The master modport is the register/FIFO fabric; the slave modport is the SPI responder.
interface spi_peripheral_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  rx_data,
      input  rx_valid
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output rx_data,
      output rx_valid
   );
endinterface

// File: rtl/spi_peripheral.sv
// SPI responder: oversamples PCLK/CS_n/COPI in the clk domain, all four CPOL/CPHA modes, MSB first.
// Optional macro SPI_PERIPH_ECHO_EN: on underrun, retransmit the last received byte instead of IDLE_FILL.
module spi_peripheral #(
   parameter int unsigned SYNC_STAGES = 2,     // legal 2..4
   parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             CPOL,
   input  logic             CPHA,
   input  logic             PCLK,
   input  logic             CS_n,
   input  logic             COPI,
   output logic             CIPO,
   output logic             BUSY,
   spi_peripheral_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] pclk_sync_q, cs_sync_q, copi_sync_q;
   logic pclk_d_q, cs_d_q;
   logic pclk_s, cs_s, copi_s;

   logic       cpol_q, cpol_d;
   logic       cpha_q, cpha_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       reload_q, reload_d;
   logic       first_q, first_d;

   logic lead_ev, trail_ev, sample_ev, shift_ev;
   logic cs_fall, cs_rise;
   logic load_tx, tx_ready;
   logic [7:0] fill_byte;

`ifdef SPI_PERIPH_ECHO_EN
   assign fill_byte = rx_data_q;
`else
   assign fill_byte = IDLE_FILL;
`endif

   // Synchronisers plus one edge-detect stage; CS_n idles high so reset cannot fake a frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pclk_sync_q <= '0;
         cs_sync_q   <= '1;
         copi_sync_q <= '0;
         pclk_d_q    <= 1'b0;
         cs_d_q      <= 1'b1;
      end else begin
         pclk_sync_q <= {pclk_sync_q[SYNC_STAGES-2:0], PCLK};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_n};
         copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
         pclk_d_q    <= pclk_s;
         cs_d_q      <= cs_s;
      end
   end

   assign pclk_s = pclk_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign copi_s = copi_sync_q[SYNC_STAGES-1];

   assign lead_ev   = (pclk_s != pclk_d_q) && (pclk_s != cpol_q);
   assign trail_ev  = (pclk_s != pclk_d_q) && (pclk_s == cpol_q);
   assign sample_ev = (state_q == StShift) && (cpha_q ? trail_ev : lead_ev);
   assign shift_ev  = (state_q == StShift) && (cpha_q ? lead_ev : trail_ev);
   assign cs_fall   = cs_d_q & ~cs_s;
   assign cs_rise   = ~cs_d_q & cs_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         tx_shift_q <= 8'h00;
         rx_shift_q <= 8'h00;
         bitcnt_q   <= 3'd0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         reload_q   <= 1'b0;
         first_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         bitcnt_q   <= bitcnt_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         reload_q   <= reload_d;
         first_q    <= first_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      bitcnt_d   = bitcnt_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      reload_d   = reload_q;
      first_d    = first_q;
      load_tx    = 1'b0;
      tx_ready   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cs_fall) begin
               cpol_d  = CPOL;
               cpha_d  = CPHA;
               state_d = StLoad;
            end
         end
         StLoad: begin
            load_tx  = 1'b1;
            bitcnt_d = 3'd0;
            reload_d = 1'b0;
            first_d  = 1'b1;
            state_d  = StShift;
         end
         StShift: begin
            // A sample coinciding with CS_n release still completes the byte.
            if (sample_ev) begin
               rx_shift_d = {rx_shift_q[6:0], copi_s};
               if (bitcnt_q == 3'd7) begin
                  rx_data_d  = {rx_shift_q[6:0], copi_s};
                  rx_valid_d = 1'b1;
                  bitcnt_d   = 3'd0;
                  reload_d   = 1'b1;
               end else begin
                  bitcnt_d = bitcnt_q + 3'd1;
               end
            end
            // Reload replaces the first shift of the next byte; CPHA=1 skips its first leading edge.
            if (shift_ev) begin
               if (reload_q) begin
                  load_tx  = 1'b1;
                  reload_d = 1'b0;
                  first_d  = 1'b0;
               end else if (cpha_q && first_q) begin
                  first_d = 1'b0;
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end
            if (cs_rise) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (load_tx) begin
         tx_ready   = bus.tx_valid;
         tx_shift_d = bus.tx_valid ? bus.tx_data : fill_byte;
      end
   end

   assign CIPO         = (state_q == StShift) ? tx_shift_q[7] : 1'b0;
   assign BUSY         = (state_q != StIdle);
   assign bus.tx_ready = tx_ready;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: directed SPI frames in all modes, abort, reset and underrun.
`timescale 1ns/1ps
module tb_spi_peripheral;

   localparam int unsigned SyncStages = 2;
   localparam int unsigned H = 80;  // half PCLK period in ns (8 clk cycles)
`ifdef SPI_PERIPH_ECHO_EN
   localparam bit Echo = 1'b1;
`else
   localparam bit Echo = 1'b0;
`endif

   logic clk, rst_n;
   logic CPOL, CPHA, PCLK, CS_n, COPI;
   logic CIPO, BUSY;

   spi_peripheral_if sif ();

   spi_peripheral #(
      .SYNC_STAGES (SyncStages),
      .IDLE_FILL   (8'hFF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .CPOL  (CPOL),
      .CPHA  (CPHA),
      .PCLK  (PCLK),
      .CS_n  (CS_n),
      .COPI  (COPI),
      .CIPO  (CIPO),
      .BUSY  (BUSY),
      .bus   (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int rx_pulses = 0;
   int tx_pulses = 0;

   logic [7:0] rx_q[$];      // expected rx_data per rx_valid
   logic [7:0] cipo_exp[$];  // expected bytes read by the controller
   logic [7:0] mosi_q[$];    // bytes the controller sends
   logic [7:0] tx_src[$];    // fabric transmit queue
   logic [7:0] last_rx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] fill(input logic [7:0] prev);
      return Echo ? prev : 8'hFF;
   endfunction

   // Fabric source: presents the head of tx_src, pops it after a tx_ready cycle.
   initial begin
      bit take;
      sif.tx_valid = 1'b0;
      sif.tx_data  = 8'h00;
      forever begin
         @(negedge clk);
         take = sif.tx_ready;
         @(posedge clk);
         #1;
         if (take && tx_src.size() > 0) void'(tx_src.pop_front());
         sif.tx_valid = (tx_src.size() != 0);
         sif.tx_data  = (tx_src.size() != 0) ? tx_src[0] : 8'h00;
      end
   end

   // Monitor: checks each received byte against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (sif.rx_valid) begin
               rx_pulses++;
               if (rx_q.size() == 0) chk("rx_unexpected", {24'h0, sif.rx_data}, 32'hFFFF_FFFF);
               else chk("rx_data", {24'h0, sif.rx_data}, {24'h0, rx_q.pop_front()});
            end
            if (sif.tx_ready) tx_pulses++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   task automatic spi_frame(input bit cpol, input bit cpha, input int nbits, input bit keep_cs,
                            input bit flip);
      logic [7:0] cur, rd;
      cur = 8'h00;
      rd  = 8'h00;
      CPOL = cpol;
      CPHA = cpha;
      PCLK = cpol;
      #H;
      CS_n = 1'b0;
      repeat (10) @(posedge clk);
      if (flip) begin
         CPOL = ~cpol;
         CPHA = ~cpha;
      end
      for (int i = 0; i < nbits; i++) begin
         if (i % 8 == 0) cur = (mosi_q.size() > 0) ? mosi_q.pop_front() : 8'h00;
         if (!cpha) begin
            COPI = cur[7 - (i % 8)];
            #H;
            rd = {rd[6:0], CIPO};
            PCLK = ~cpol;
            #H;
            PCLK = cpol;
         end else begin
            #H;
            PCLK = ~cpol;
            COPI = cur[7 - (i % 8)];
            #H;
            rd = {rd[6:0], CIPO};
            PCLK = cpol;
         end
         if (i % 8 == 7) begin
            if (cipo_exp.size() == 0) chk("cipo_unexpected", {24'h0, rd}, 32'hFFFF_FFFF);
            else chk("cipo_byte", {24'h0, rd}, {24'h0, cipo_exp.pop_front()});
         end
      end
      if (!keep_cs) begin
         #H;
         CS_n = 1'b1;
         repeat (12) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int rx0, tx0, n;
      rst_n = 1'b0;
      CPOL = 1'b0; CPHA = 1'b0; PCLK = 1'b0; CS_n = 1'b1; COPI = 1'b0;
      last_rx = 8'h00;
      #12;
      chk("rst_cipo", {31'h0, CIPO}, 32'h0);
      chk("rst_busy", {31'h0, BUSY}, 32'h0);
      chk("rst_rx_valid", {31'h0, sif.rx_valid}, 32'h0);
      chk("rst_tx_ready", {31'h0, sif.tx_ready}, 32'h0);
      chk("rst_rx_data", {24'h0, sif.rx_data}, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      // T1: mode 0, one byte each way, one tx_ready
      tx0 = tx_pulses;
      tx_src.push_back(8'h3C);
      mosi_q.push_back(8'hA5); cipo_exp.push_back(8'h3C); rx_q.push_back(8'hA5);
      spi_frame(1'b0, 1'b0, 8, 1'b0, 1'b0);
      last_rx = 8'hA5;
      chk("t1_tx_ready_cnt", tx_pulses - tx0, 1);
      chk("t1_rx_pending", rx_q.size(), 0);

      // T2: mode 3, two bytes, underrun throughout
      tx0 = tx_pulses;
      mosi_q.push_back(8'h12); mosi_q.push_back(8'h34);
      cipo_exp.push_back(fill(last_rx)); cipo_exp.push_back(fill(8'h12));
      rx_q.push_back(8'h12); rx_q.push_back(8'h34);
      spi_frame(1'b1, 1'b1, 16, 1'b0, 1'b0);
      last_rx = 8'h34;
      chk("t2_tx_ready_cnt", tx_pulses - tx0, 0);
      chk("t2_rx_pending", rx_q.size(), 0);

      // T3: mode 1, CS_n released after 5 bits
      rx0 = rx_pulses; tx0 = tx_pulses;
      mosi_q.push_back(8'hF0);
      spi_frame(1'b0, 1'b1, 5, 1'b1, 1'b0);
      chk("t3_busy_mid", {31'h0, BUSY}, 32'h1);
      @(negedge clk);
      CS_n = 1'b1;
      n = 0;
      while (BUSY && n < int'(SyncStages) + 2) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t3_busy_drop", {31'h0, BUSY}, 32'h0);
      repeat (12) @(posedge clk);
      chk("t3_rx_valid_cnt", rx_pulses - rx0, 0);
      chk("t3_rx_data_hold", {24'h0, sif.rx_data}, {24'h0, last_rx});
      chk("t3_tx_ready_cnt", tx_pulses - tx0, 0);

      // T4: mode 2, reset after 3 bits, then a full frame
      mosi_q.push_back(8'h0F);
      spi_frame(1'b1, 1'b0, 3, 1'b1, 1'b0);
      chk("t4_busy_mid", {31'h0, BUSY}, 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_cipo", {31'h0, CIPO}, 32'h0);
      chk("t4_rst_busy", {31'h0, BUSY}, 32'h0);
      chk("t4_rst_rx_valid", {31'h0, sif.rx_valid}, 32'h0);
      chk("t4_rst_tx_ready", {31'h0, sif.tx_ready}, 32'h0);
      chk("t4_rst_rx_data", {24'h0, sif.rx_data}, 32'h0);
      CS_n = 1'b1;
      last_rx = 8'h00;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      tx0 = tx_pulses;
      tx_src.push_back(8'h96);
      mosi_q.push_back(8'hC3); cipo_exp.push_back(8'h96); rx_q.push_back(8'hC3);
      spi_frame(1'b1, 1'b0, 8, 1'b0, 1'b0);
      last_rx = 8'hC3;
      chk("t4_tx_ready_cnt", tx_pulses - tx0, 1);
      chk("t4_rx_data", {24'h0, sif.rx_data}, 32'hC3);
      chk("t4_rx_pending", rx_q.size(), 0);

      // T5: back-to-back mode 0 then mode 1; mode pins toggled mid-frame in the second
      tx0 = tx_pulses;
      tx_src.push_back(8'hE7);
      mosi_q.push_back(8'h81); cipo_exp.push_back(8'hE7); rx_q.push_back(8'h81);
      spi_frame(1'b0, 1'b0, 8, 1'b0, 1'b0);
      tx_src.push_back(8'h19);
      repeat (2) @(posedge clk);
      mosi_q.push_back(8'h7E); cipo_exp.push_back(8'h19); rx_q.push_back(8'h7E);
      spi_frame(1'b0, 1'b1, 8, 1'b0, 1'b1);
      last_rx = 8'h7E;
      chk("t5_tx_ready_cnt", tx_pulses - tx0, 2);
      chk("t5_rx_pending", rx_q.size(), 0);

      // T6: mode 0, 8'h5A then 8'h00 with tx_valid low
      tx0 = tx_pulses;
      mosi_q.push_back(8'h5A); mosi_q.push_back(8'h00);
      cipo_exp.push_back(fill(last_rx)); cipo_exp.push_back(fill(8'h5A));
      rx_q.push_back(8'h5A); rx_q.push_back(8'h00);
      spi_frame(1'b0, 1'b0, 16, 1'b0, 1'b0);
      last_rx = 8'h00;
      chk("t6_tx_ready_cnt", tx_pulses - tx0, 0);
      chk("t6_rx_pending", rx_q.size(), 0);

      // T7: mode 1, three bytes, two queued tx bytes then underrun
      tx0 = tx_pulses;
      tx_src.push_back(8'hA1); tx_src.push_back(8'hB2);
      repeat (3) @(posedge clk);
      mosi_q.push_back(8'h11); mosi_q.push_back(8'h22); mosi_q.push_back(8'h33);
      cipo_exp.push_back(8'hA1); cipo_exp.push_back(8'hB2); cipo_exp.push_back(fill(8'h22));
      rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33);
      spi_frame(1'b0, 1'b1, 24, 1'b0, 1'b0);
      last_rx = 8'h33;
      chk("t7_tx_ready_cnt", tx_pulses - tx0, 2);
      chk("t7_rx_pending", rx_q.size(), 0);
      chk("t7_cipo_pending", cipo_exp.size(), 0);
      chk("idle_cipo", {31'h0, CIPO}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
